sobel_window_ctrl: RTL
======================

// Module: sobel_window_ctrl
// PURPOSE
//  Raster-stream front end and scheduler for the 3x3 Sobel kernel (sobel).
//  - Accepts 8-bit pixels in raster order and keeps two line buffers.
//  - Drives the kernel's eight neighbour inputs (p0..p8, no p4) from the assembled window.
//  - Tracks the kernel's fixed 3-cycle latency and re-times results into an output FIFO with valid/ready.
//  - Credits the FIFO so a free-running kernel never drops a result.
// PARAMETERS
//  IMG_W     64  pixels per line (>=3)
//  IMG_H     64  lines per frame (>=3)
//  FIFO_D     4  output FIFO depth (>= KERN_LAT+1)
//  KERN_LAT   3  kernel input-to-out latency in clk cycles
// PORTS
//  clk          in   1  rising-edge clock
//  rst          in   1  synchronous, active-high reset
//  in_pix       in   8  input pixel, raster order
//  in_valid     in   1  in_pix valid
//  in_ready     out  1  controller accepts in_pix this cycle
//  k_p0..k_p8   out  9  kernel window taps (8 ports, p4 omitted), {1'b0,pix}
//  k_out        in   8  kernel result (sobel.out)
//  out_pix      out  8  edge magnitude
//  out_valid    out  1  out_pix valid
//  out_ready    in   1  downstream accepts out_pix
//  out_last     out  1  with out_valid: final result of the frame
//  frame_done   out  1  1-cycle pulse when out_last is accepted
// BEHAVIOUR
//  - Reset state: all outputs 0; counters, credits, FIFO and issue pipe cleared; in_ready=0 for exactly the first cycle after rst deasserts.
//  - Input accept: in_valid & in_ready.
//    - col increments; on col==IMG_W-1 it wraps to 0 and row increments.
//    - On row==IMG_H-1 && col==IMG_W-1, row and col wrap to 0 (next frame).
//    - Line buffers shift on every accept.
//  - Window: pixel (r,c) accepted with r>=2 && c>=2 forms a window centred on (r-1,c-1).
//    - Taps: p0=(r-2,c-2), p1=(r-2,c-1), p2=(r-2,c), p3=(r-1,c-2), p5=(r-1,c), p6=(r,c-2), p7=(r,c-1), p8=(r,c).
//    - k_p* registered: they change only on the cycle after an accept.
//  - Issue: an issue pipe, KERN_LAT deep and 1 bit wide (plus a last flag), shifts every cycle.
//    - An issued window sets bit0.
//    - At the pipe exit, k_out is pushed into the FIFO together with its last flag.
//  - Credits: in_ready = (fifo_cnt + inflight < FIFO_D), with inflight = popcount(issue pipe).
//    - A push and a pop in the same cycle leave fifo_cnt unchanged.
//    - The FIFO never overflows; that is an assertion.
//  - Output: out_valid = (fifo_cnt != 0); show-ahead, so out_pix is stable while out_valid && !out_ready.
//  - Reset mid-frame: the same as power-on reset; any in-flight and FIFO results are discarded, with no partial frame_done.
//  - Arithmetic: taps are 9 bits, upper bit 0. The kernel saturates to 0xFF; the controller does not alter k_out.
// CONFIGURATION
//  SOBEL_BORDER_EN defined:
//  - Every input pixel yields exactly one output: IMG_W*IMG_H results per frame.
//  - Border results (row 0, row IMG_H-1, col 0, col IMG_W-1) are 8'h00.
//    - They are pushed through a zero-result path that occupies the same pipe slot.
//    - Border and interior results keep raster order.
//  - The trailing last row and last column are flushed with internally generated zero-window slots.
//  - in_ready stays low during the flush.
//  - out_last marks the result at position (IMG_H-1, IMG_W-1).
//  SOBEL_BORDER_EN undefined:
//  - Interior results only: (IMG_W-2)*(IMG_H-2) results per frame.
//  - out_last marks the window centred on (IMG_H-2, IMG_W-2).
// STRUCTURE
//  - Package sobel_pkg: PIX_W=8, TAP_W=9, KERN_LAT=3, and a typedef win_t with 8 taps.
//  - Sub-module sobel_line_buf: a single IMG_W x 8 shift RAM. It is instantiated twice (rows r-1 and r-2).
//  - The FIFO is local and built from registers.
// TESTING
//  - Flat frame, 8x8 all 0x40, out_ready=1 -> 36 results all 0x00 (border off) or 64 results (border on); out_last on the final one.
//  - Vertical step, 8x8, cols 0-3=0x00 and cols 4-7=0xFF -> interior cols 3 and 4 = 0xFF, all other interior results 0x00.
//  - Horizontal step, rows 0-3=0x00 and rows 4-7=0x10 -> interior rows 3 and 4 = 0x40, others 0x00.
//  - Backpressure: out_ready=0 for 20 cycles mid-frame -> in_ready falls within FIFO_D accepts and no results are lost or duplicated; the final count matches the expected count.
//  - Reset at pixel 30 of frame 1, then a full frame 2 -> no output from frame 1 after rst; frame 2 output is bit-exact against the golden model; exactly one frame_done.
//  - Back-to-back frames with in_valid=1 held continuously -> frame_done pulses once per frame; row/col wrap is correct with no bubble between frames (border off).

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window controller.
// Used by sobel_line_buf and sobel_window_ctrl.
package sobel_pkg;

    localparam int PIX_W    = 8;
    localparam int TAP_W    = 9;
    localparam int KERN_LAT = 3;

    typedef struct packed {
        logic [TAP_W-1:0] p0;
        logic [TAP_W-1:0] p1;
        logic [TAP_W-1:0] p2;
        logic [TAP_W-1:0] p3;
        logic [TAP_W-1:0] p5;
        logic [TAP_W-1:0] p6;
        logic [TAP_W-1:0] p7;
        logic [TAP_W-1:0] p8;
    } win_t;

    typedef struct packed {
        logic vld;
        logic zero;
        logic last;
    } slot_t;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_FLUSH
    } ctrl_state_t;

    function automatic logic [TAP_W-1:0] to_tap(
        input logic [PIX_W-1:0] p
    );
        return {1'b0, p};
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of pixel history as a shift RAM.
// dout is the pixel shifted in DEPTH accepts earlier.
module sobel_line_buf #(
    parameter int DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        shift_en,
    input  logic [sobel_pkg::PIX_W-1:0] din,
    output logic [sobel_pkg::PIX_W-1:0] dout
);
    import sobel_pkg::*;

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel 3x3 front end: window assembly, kernel latency tracking, credited FIFO.
// Build option SOBEL_BORDER_EN: one result per pixel with zero borders.
module sobel_window_ctrl #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int FIFO_D   = 4,
    parameter int KERN_LAT = sobel_pkg::KERN_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [sobel_pkg::PIX_W-1:0] in_pix,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [sobel_pkg::TAP_W-1:0] k_p0,
    output logic [sobel_pkg::TAP_W-1:0] k_p1,
    output logic [sobel_pkg::TAP_W-1:0] k_p2,
    output logic [sobel_pkg::TAP_W-1:0] k_p3,
    output logic [sobel_pkg::TAP_W-1:0] k_p5,
    output logic [sobel_pkg::TAP_W-1:0] k_p6,
    output logic [sobel_pkg::TAP_W-1:0] k_p7,
    output logic [sobel_pkg::TAP_W-1:0] k_p8,
    input  logic [sobel_pkg::PIX_W-1:0] k_out,
    output logic [sobel_pkg::PIX_W-1:0] out_pix,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        frame_done
);
    import sobel_pkg::*;

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int PW   = $clog2(FIFO_D);
    localparam int CNTW = $clog2(FIFO_D + 1);
    localparam int FW   = $clog2(IMG_W + 2);

    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0]   ONE_C    = CW'(1);
    localparam logic [RW-1:0]   ONE_R    = RW'(1);
    localparam logic [CW-1:0]   TWO_C    = CW'(2);
    localparam logic [RW-1:0]   TWO_R    = RW'(2);
    localparam logic [PW-1:0]   PTR_LAST = PW'(FIFO_D - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_D);

    ctrl_state_t state, state_n;
    logic [FW-1:0] flush_cnt, flush_n;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic accept, at_eol, at_eof, interior;
    logic credit_ok, fl_issue, fl_last;
    logic run_issue, run_zero, run_last;
    slot_t issue, exit_slot;
    slot_t [KERN_LAT-1:0] pipe;
    int occ;

    logic [PIX_W-1:0] lb1_out, lb2_out;
    logic [PIX_W-1:0] t0, t1, m0, m1, b0, b1;
    win_t win;

    logic [PIX_W-1:0] fifo_pix [FIFO_D];
    logic [FIFO_D-1:0] fifo_last;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CNTW-1:0] fifo_cnt;
    logic push, pop;
    logic [PIX_W-1:0] push_pix;

    assign accept   = in_valid & in_ready;
    assign at_eol   = (col == COL_LAST);
    assign at_eof   = at_eol && (row == ROW_LAST);
    assign interior = (row >= TWO_R) && (col >= TWO_C);

    // Credits cover every slot already committed to the kernel.
    always_comb begin
        occ = 32'(fifo_cnt);
        for (int i = 0; i < KERN_LAT; i++) begin
            occ = occ + 32'(pipe[i].vld);
        end
        credit_ok = (occ < FIFO_D);
    end

    assign in_ready = (state == S_RUN) && credit_ok;

    always_comb begin
        state_n  = state;
        flush_n  = flush_cnt;
        fl_issue = 1'b0;
        fl_last  = 1'b0;
        unique case (state)
            S_INIT: state_n = S_RUN;
            S_RUN: begin
`ifdef SOBEL_BORDER_EN
                if (accept && at_eof) begin
                    state_n = S_FLUSH;
                    flush_n = FW'(IMG_W + 1);
                end
`endif
            end
            S_FLUSH: begin
                if (credit_ok) begin
                    fl_issue = 1'b1;
                    fl_last  = (flush_cnt == FW'(1));
                    flush_n  = flush_cnt - FW'(1);
                    if (fl_last) state_n = S_RUN;
                end
            end
            default: state_n = S_INIT;
        endcase
    end

`ifdef SOBEL_BORDER_EN
    // Pixel (r,c) releases result (r-1,c-1); col 0 releases (r-2,W-1).
    assign run_issue = accept && (row >= ONE_R) &&
                       ((col >= ONE_C) || (row >= TWO_R));
    assign run_zero  = !interior;
    assign run_last  = 1'b0;
`else
    assign run_issue = accept && interior;
    assign run_zero  = 1'b0;
    assign run_last  = at_eof;
`endif

    assign issue.vld  = run_issue | fl_issue;
    assign issue.zero = run_zero | fl_issue;
    assign issue.last = fl_issue ? fl_last : run_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            flush_cnt  <= '0;
            col        <= '0;
            row        <= '0;
            pipe       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            flush_cnt  <= flush_n;
            pipe       <= {pipe[KERN_LAT-2:0], issue};
            frame_done <= pop & out_last;
            if (accept) begin
                if (at_eol) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ONE_R;
                end else begin
                    col <= col + ONE_C;
                end
            end
        end
    end

    sobel_line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk      (clk),
        .shift_en (accept),
        .din      (in_pix),
        .dout     (lb1_out)
    );

    sobel_line_buf #(.DEPTH(IMG_W)) u_lb2 (
        .clk      (clk),
        .shift_en (accept),
        .din      (lb1_out),
        .dout     (lb2_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            win <= '0;
            t0  <= '0;
            t1  <= '0;
            m0  <= '0;
            m1  <= '0;
            b0  <= '0;
            b1  <= '0;
        end else if (accept) begin
            win.p0 <= to_tap(t0);
            win.p1 <= to_tap(t1);
            win.p2 <= to_tap(lb2_out);
            win.p3 <= to_tap(m0);
            win.p5 <= to_tap(lb1_out);
            win.p6 <= to_tap(b0);
            win.p7 <= to_tap(b1);
            win.p8 <= to_tap(in_pix);
            t0 <= t1;
            t1 <= lb2_out;
            m0 <= m1;
            m1 <= lb1_out;
            b0 <= b1;
            b1 <= in_pix;
        end
    end

    assign k_p0 = win.p0;
    assign k_p1 = win.p1;
    assign k_p2 = win.p2;
    assign k_p3 = win.p3;
    assign k_p5 = win.p5;
    assign k_p6 = win.p6;
    assign k_p7 = win.p7;
    assign k_p8 = win.p8;

    assign exit_slot = pipe[KERN_LAT-1];
    assign push      = exit_slot.vld;
    assign push_pix  = exit_slot.zero ? '0 : k_out;
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid & out_ready;
    assign out_pix   = out_valid ? fifo_pix[rd_ptr] : '0;
    assign out_last  = out_valid & fifo_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_pix[i] <= '0;
            end
            fifo_last <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            if (push) begin
                fifo_pix[wr_ptr]  <= push_pix;
                fifo_last[wr_ptr] <= exit_slot.last;
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNTW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNTW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_cnt == CNT_FULL)));

endmodule
